// File: rtl/ps2_key_gen.sv
// ps2_key_gen
// ---------------------------------------------------------------------------
// Turns raw PS/2 set-2 keyboard traffic into the 11-bit ps2_key event word
// used by the keyboard decoder in the clk_sys domain.
//
// Event protocol (the only "handshake" this block has): there is no
// valid/ready pair. A new event is signalled solely by bit 10 of ps2_key
// changing. The consumer must treat every toggle of bit 10 as exactly one
// event and read bits 9:0 in that same cycle. The word holds its value
// until the next event.
//
// Ports
//   clk_sys      in   system clock (48 MHz nominal)
//   RESET        in   synchronous, active-high reset
//   ps2_clk_in   in   raw PS/2 clock line (asynchronous)
//   ps2_data_in  in   raw PS/2 data line (asynchronous)
//   ps2_key      out  {toggle, pressed, extended, code[7:0]}
//   frame_err    out  one-cycle pulse on start/parity/stop error or on a
//                     timeout abort of a partial frame
//
// Parameters
//   FILTER_LEN   cycles a synchronised ps2_clk level must hold to be accepted
//   TIMEOUT      idle cycles inside a frame before the frame is abandoned
//   TW           width of the timeout counter (must hold TIMEOUT)
//
// Optional build macro
//   PS2_TYPEMATIC_FILTER_EN  adds a 512-entry held-key bitmap that suppresses
//                            typematic repeat make codes.
// ---------------------------------------------------------------------------
module ps2_key_gen #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 96000,
  parameter int TW         = 17
) (
  input  logic        clk_sys,
  input  logic        RESET,
  input  logic        ps2_clk_in,
  input  logic        ps2_data_in,
  output logic [10:0] ps2_key,
  output logic        frame_err
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  // Frame FSM state; r_state is the observation point for the FSM.
  state_t r_state;
  state_t w_next_state;

  // Input conditioning
  logic          r_clk_s1, r_clk_s2;
  logic          r_dat_s1, r_dat_s2;
  logic          r_filt_clk;
  logic [FW-1:0] r_filt_cnt;
  logic          w_strobe;

  // Frame datapath
  logic [7:0]    r_shift;
  logic [2:0]    r_bit_cnt;
  logic          r_parity;
  logic [TW-1:0] r_to_cnt;
  logic          w_shift_en, w_bit_clr, w_par_en;
  logic          w_stop_ok, w_stop_bad, w_start_err, w_timeout;

  // Byte processing
  logic          r_byte_vld;
  logic [7:0]    r_byte;
  logic          r_ext, r_rel;
  logic [2:0]    r_skip;
  logic [10:0]   r_ps2_key;
  logic          r_frame_err;
  logic          w_is_key;
  logic          w_emit_ok;

  assign ps2_key   = r_ps2_key;
  assign frame_err = r_frame_err;

  // Two-flop synchronisers; lines idle high so they reset high.
  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= ps2_clk_in;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_data_in;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // Glitch filter: the filtered clock follows the synchronised clock only
  // after FILTER_LEN consecutive differing samples; any agreeing sample
  // restarts the count.
  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      r_filt_clk <= 1'b1;
      r_filt_cnt <= '0;
    end else if (r_clk_s2 == r_filt_clk) begin
      r_filt_cnt <= '0;
    end else if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
      r_filt_clk <= r_clk_s2;
      r_filt_cnt <= '0;
    end else begin
      r_filt_cnt <= r_filt_cnt + FW'(1);
    end
  end

  // Strobe is the cycle in which the filtered clock commits a 1->0 change;
  // r_dat_s2 is the bit value for that strobe.
  assign w_strobe = r_filt_clk && !r_clk_s2 && (r_filt_cnt == FW'(FILTER_LEN - 1));

  // Timeout only counts cycles with no strobe while a frame is open.
  assign w_timeout = (r_state != ST_IDLE) && !w_strobe &&
                     (r_to_cnt == TW'(TIMEOUT - 1));

  // Frame FSM: next state and datapath controls.
  always_comb begin
    w_next_state = r_state;
    w_shift_en   = 1'b0;
    w_bit_clr    = 1'b0;
    w_par_en     = 1'b0;
    w_stop_ok    = 1'b0;
    w_stop_bad   = 1'b0;
    w_start_err  = 1'b0;
    if (w_strobe) begin
      case (r_state)
        ST_IDLE: begin
          if (!r_dat_s2) begin
            w_next_state = ST_DATA;
            w_bit_clr    = 1'b1;
          end else begin
            w_start_err  = 1'b1;
          end
        end
        ST_DATA: begin
          w_shift_en = 1'b1;
          if (r_bit_cnt == 3'd7) w_next_state = ST_PARITY;
        end
        ST_PARITY: begin
          w_par_en     = 1'b1;
          w_next_state = ST_STOP;
        end
        ST_STOP: begin
          w_next_state = ST_IDLE;
          // Odd parity: data bits plus parity bit must hold an odd count of ones.
          if (r_dat_s2 && ((^r_shift) ^ r_parity)) w_stop_ok  = 1'b1;
          else                                     w_stop_bad = 1'b1;
        end
        default: w_next_state = ST_IDLE;
      endcase
    end else if (w_timeout) begin
      w_next_state = ST_IDLE;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (RESET) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  // Frame datapath registers.
  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_parity    <= 1'b0;
      r_to_cnt    <= '0;
      r_byte_vld  <= 1'b0;
      r_byte      <= '0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_shift_en) r_shift <= {r_dat_s2, r_shift[7:1]};
      if (w_bit_clr || w_timeout) r_bit_cnt <= '0;
      else if (w_shift_en)        r_bit_cnt <= r_bit_cnt + 3'd1;
      if (w_par_en) r_parity <= r_dat_s2;
      if (w_strobe || w_timeout || r_state == ST_IDLE) r_to_cnt <= '0;
      else                                              r_to_cnt <= r_to_cnt + TW'(1);
      r_byte_vld  <= w_stop_ok;
      if (w_stop_ok) r_byte <= r_shift;
      r_frame_err <= w_start_err | w_stop_bad | w_timeout;
    end
  end

  // Anything that is not a prefix or a keyboard status/ack byte is a key code.
  always_comb begin
    w_is_key = 1'b1;
    case (r_byte)
      8'hE0, 8'hE1, 8'hF0, 8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: w_is_key = 1'b0;
      default: w_is_key = 1'b1;
    endcase
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  // Held-key bitmap indexed by {ext, code}. Cleared one entry per cycle
  // after reset; while the sweep runs, keys pass through unfiltered and the
  // bitmap is not updated.
  logic [511:0] r_held;
  logic [8:0]   r_clr_idx;
  logic         r_clearing;
  logic         w_map_we;
  logic [8:0]   w_map_idx;

  assign w_map_idx = {r_ext, r_byte};
  assign w_map_we  = r_byte_vld && (r_skip == 3'd0) && w_is_key && !r_clearing;
  // A make of a key already held is a typematic repeat and is dropped.
  assign w_emit_ok = r_rel || r_clearing || !r_held[w_map_idx];

  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      r_clr_idx  <= '0;
      r_clearing <= 1'b1;
    end else if (r_clearing) begin
      r_clr_idx <= r_clr_idx + 9'd1;
      if (r_clr_idx == 9'd511) r_clearing <= 1'b0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (r_clearing)    r_held[r_clr_idx] <= 1'b0;
    else if (w_map_we) r_held[w_map_idx] <= ~r_rel;
  end
`else
  assign w_emit_ok = 1'b1;
`endif

  // Byte processing, one cycle after a valid stop bit.
  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      r_ext     <= 1'b0;
      r_rel     <= 1'b0;
      r_skip    <= '0;
      r_ps2_key <= '0;
    end else begin
      if (r_byte_vld) begin
        if (r_skip != 3'd0) begin
          r_skip <= r_skip - 3'd1;
        end else if (r_byte == 8'hE1) begin
          // Pause: swallow the remaining 7 bytes of the sequence.
          r_skip <= 3'd7;
        end else if (r_byte == 8'hE0) begin
          r_ext <= 1'b1;
        end else if (r_byte == 8'hF0) begin
          r_rel <= 1'b1;
        end else if (w_is_key) begin
          if (w_emit_ok) r_ps2_key <= {~r_ps2_key[10], ~r_rel, r_ext, r_byte};
          r_ext <= 1'b0;
          r_rel <= 1'b0;
        end
      end
      // A corrupt byte leaves the sequence context unknown; drop it.
      if (w_stop_bad) begin
        r_ext  <= 1'b0;
        r_rel  <= 1'b0;
        r_skip <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_gen.sv
// Bench for ps2_key_gen: directed PS/2 frames, expected events queued by the
// driver and checked by an independent monitor on every ps2_key change and
// every frame_err pulse.
module tb_ps2_key_gen;

  localparam int FILTER_LEN = 8;
  localparam int TIMEOUT    = 3000;
  localparam int TW         = 12;
  localparam int HALF       = 40;

  logic        clk_sys     = 1'b0;
  logic        RESET       = 1'b1;
  logic        ps2_clk_in  = 1'b1;
  logic        ps2_data_in = 1'b1;
  logic [10:0] ps2_key;
  logic        frame_err;

  ps2_key_gen #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT    (TIMEOUT),
    .TW         (TW)
  ) dut (
    .clk_sys     (clk_sys),
    .RESET       (RESET),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_key     (ps2_key),
    .frame_err   (frame_err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [10:0] exp_q[$];
  int          exp_cyc_q[$];
  logic [0:0]  err_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string name, input logic [10:0] got, input logic [10:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // ---------------- monitor ----------------
  logic [10:0] prev_key = '0;
  logic        prev_err = 1'b0;

  always @(negedge clk_sys) begin
    if (RESET) begin
      prev_key = ps2_key;
      prev_err = 1'b0;
    end else begin
      if (ps2_key !== prev_key) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL key_unexpected got=%h expected=none", ps2_key);
        end else begin
          check("key_value", ps2_key, exp_q.pop_front());
          check_int("key_latency", cyc, exp_cyc_q.pop_front());
        end
        prev_key = ps2_key;
      end
      if (frame_err) begin
        if (prev_err) begin
          n_cmp++;
          n_bad++;
          $display("FAIL err_width got=2+ cycles expected=1 cycle");
        end else if (err_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL err_unexpected got=1 expected=0 at cycle %0d", cyc);
        end else begin
          check("err_pulse", {10'd0, frame_err}, {10'd0, err_q.pop_front()});
        end
      end
      prev_err = frame_err;
    end
  end

  // ---------------- driver tasks ----------------
  // Sends bits[0..nbits-1] as PS/2 clock periods. At the falling edge of the
  // last bit, queues the expected event (due 3+FILTER_LEN cycles later:
  // 2 sync + FILTER_LEN filter - 1 + validate + register) and/or an error.
  task automatic send_bits(input logic [10:0] bits, input int nbits,
                           input bit push_key, input logic [10:0] exp_key,
                           input bit push_err);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk_sys);
      ps2_data_in = bits[i];
      repeat (HALF) @(negedge clk_sys);
      ps2_clk_in = 1'b0;
      if (i == nbits - 1) begin
        if (push_key) begin
          exp_q.push_back(exp_key);
          exp_cyc_q.push_back(cyc + 3 + FILTER_LEN);
        end
        if (push_err) err_q.push_back(1'b1);
      end
      repeat (HALF) @(negedge clk_sys);
      ps2_clk_in = 1'b1;
    end
    @(negedge clk_sys);
    ps2_data_in = 1'b1;
    repeat (100) @(negedge clk_sys);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par,
                            input bit ev, input logic [10:0] k);
    logic par;
    par = (~^b) ^ bad_par;
    send_bits({1'b1, par, b, 1'b0}, 11, ev, k, bad_par);
  endtask

  task automatic do_reset(input string name);
    @(negedge clk_sys);
    RESET = 1'b1;
    repeat (3) @(negedge clk_sys);
    check({name, "_key"}, ps2_key, 11'h000);
    check({name, "_err"}, {10'd0, frame_err}, 11'h000);
    RESET = 1'b0;
    repeat (5) @(negedge clk_sys);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    do_reset("rst0");

    // Plain make, then break.
    send_frame(8'h1C, 1'b0, 1'b1, 11'h61C);
    send_frame(8'hF0, 1'b0, 1'b0, 11'h000);
    send_frame(8'h1C, 1'b0, 1'b1, 11'h01C);

    // Extended make and extended break.
    do_reset("rst1");
    send_frame(8'hE0, 1'b0, 1'b0, 11'h000);
    send_frame(8'h75, 1'b0, 1'b1, 11'h775);
    send_frame(8'hE0, 1'b0, 1'b0, 11'h000);
    send_frame(8'hF0, 1'b0, 1'b0, 11'h000);
    send_frame(8'h75, 1'b0, 1'b1, 11'h175);

    // Parity error: error pulse, no event; next good byte unaffected.
    send_frame(8'h29, 1'b1, 1'b0, 11'h000);
    send_frame(8'h29, 1'b0, 1'b1, 11'h629);

    // Start bit of 1 seen in IDLE.
    send_bits(11'h001, 1, 1'b0, 11'h000, 1'b1);

    // Partial frame (start + 4 bits) abandoned by timeout.
    do_reset("rst2");
    send_bits(11'h00A, 5, 1'b0, 11'h000, 1'b1);
    repeat (TIMEOUT + 500) @(negedge clk_sys);
    send_frame(8'h29, 1'b0, 1'b1, 11'h629);

    // Repeated makes then break.
    do_reset("rst3");
    send_frame(8'h1C, 1'b0, 1'b1, 11'h61C);
`ifdef PS2_TYPEMATIC_FILTER_EN
    send_frame(8'h1C, 1'b0, 1'b0, 11'h000);
    send_frame(8'h1C, 1'b0, 1'b0, 11'h000);
`else
    send_frame(8'h1C, 1'b0, 1'b1, 11'h21C);
    send_frame(8'h1C, 1'b0, 1'b1, 11'h61C);
`endif
    send_frame(8'hF0, 1'b0, 1'b0, 11'h000);
    send_frame(8'h1C, 1'b0, 1'b1, 11'h01C);

    // Pause sequence: E1 + 7 bytes swallowed, following key decodes normally.
    send_frame(8'hE1, 1'b0, 1'b0, 11'h000);
    send_frame(8'h14, 1'b0, 1'b0, 11'h000);
    send_frame(8'h77, 1'b0, 1'b0, 11'h000);
    send_frame(8'hE1, 1'b0, 1'b0, 11'h000);
    send_frame(8'hF0, 1'b0, 1'b0, 11'h000);
    send_frame(8'h14, 1'b0, 1'b0, 11'h000);
    send_frame(8'hF0, 1'b0, 1'b0, 11'h000);
    send_frame(8'h77, 1'b0, 1'b0, 11'h000);
    send_frame(8'h1C, 1'b0, 1'b1, 11'h61C);

    // Reset in the middle of a frame drops the partial frame.
    send_bits(11'h006, 4, 1'b0, 11'h000, 1'b0);
    do_reset("rst4");
    send_frame(8'h1C, 1'b0, 1'b1, 11'h61C);

    repeat (50) @(negedge clk_sys);
    check("events_drained", 11'(exp_q.size()), 11'd0);
    check("errors_drained", 11'(err_q.size()), 11'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
